// File: rtl/opcode_decoder_pipe_pkg.sv
// Shared defaults and opcode names for the opcode decoder pipe.
// The select width is derived from the opcode width through nsel_of().
package opcode_decoder_pipe_pkg;

    localparam int OPW_DEF  = 3;
    localparam int CNTW_DEF = 16;

    typedef enum logic [OPW_DEF-1:0] {
        OP_ALU = 3'd0,
        OP_SHF = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_LD  = 3'd4,
        OP_ST  = 3'd5,
        OP_BR  = 3'd6,
        OP_SYS = 3'd7
    } opcode_e;

    function automatic int nsel_of(input int opw);
        return 1 << opw;
    endfunction

endpackage

// File: rtl/opcode_decoder_pipe_fifo2.sv
// Two-entry synchronous FIFO with a registered ready and 1-bit wrapping pointers.
// Read data is forced to zero while empty so downstream sees clean fields.
module fifo2_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ready
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             r_rdy;
    logic             w_do_push;
    logic             w_do_pop;
    logic [1:0]       w_cnt_nxt;

    assign o_full    = (r_cnt == 2'd2);
    assign o_empty   = (r_cnt == 2'd0);
    assign o_ready   = r_rdy;
    assign w_do_push = i_push & r_rdy;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_cnt_nxt = r_cnt + 2'(w_do_push) - 2'(w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

    // Ready comes from next occupancy, so it never depends on this cycle's pop input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
            r_rdy    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop)
                r_rptr <= ~r_rptr;
            r_cnt <= w_cnt_nxt;
            r_rdy <= (w_cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/opcode_decoder_pipe.sv
// Registered opcode -> one-hot select decoder with enable mask, illegal flag,
// a 2-entry output buffer and saturating dispatch/error counters.
module opcode_decoder_pipe
    import opcode_decoder_pipe_pkg::*;
#(
    parameter  int OPW  = OPW_DEF,
    parameter  int CNTW = CNTW_DEF,
    localparam int NSEL = nsel_of(OPW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  opcode,
    input  logic [NSEL-1:0] en_mask,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NSEL-1:0] select,
    output logic            illegal,
    output logic [CNTW-1:0] disp_cnt,
    output logic [CNTW-1:0] err_cnt
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic            w_legal;
    logic [NSEL-1:0] w_sel;
    logic            w_ill;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [NSEL:0]   w_head;
    logic [CNTW-1:0] r_disp;
    logic [CNTW-1:0] r_err;

    assign w_legal = en_mask[opcode];
    assign w_sel   = w_legal ? (NSEL'(1) << opcode) : '0;
    assign w_ill   = ~w_legal;
    assign w_push  = in_valid & in_ready & ~w_full;
    assign w_pop   = out_valid & out_ready;

    fifo2_sync #(.WIDTH(NSEL + 1)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({w_ill, w_sel}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ready (in_ready)
    );

    assign out_valid = ~w_empty;
    assign select    = w_head[NSEL-1:0];
    assign illegal   = w_head[NSEL];
    assign disp_cnt  = r_disp;
    assign err_cnt   = r_err;

    // Errors are counted at acceptance, dispatches at output transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp <= '0;
            r_err  <= '0;
        end else begin
            if (w_pop)
                r_disp <= sat_inc(r_disp);
            if (w_push && w_ill)
                r_err <= sat_inc(r_err);
        end
    end

endmodule

// File: tb/tb_opcode_decoder_pipe.sv
// Directed self-checking bench for opcode_decoder_pipe (default and CNTW=4 instances).
module tb_opcode_decoder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [7:0]  en_mask;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  select;
    logic        illegal;
    logic [15:0] disp_cnt;
    logic [15:0] err_cnt;

    logic        in_valid4;
    logic        in_ready4;
    logic [2:0]  opcode4;
    logic [7:0]  en_mask4;
    logic        out_valid4;
    logic        out_ready4;
    logic [7:0]  select4;
    logic        illegal4;
    logic [3:0]  disp_cnt4;
    logic [3:0]  err_cnt4;

    int n_vec = 0;
    int n_err = 0;

    opcode_decoder_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .en_mask(en_mask),
        .out_valid(out_valid), .out_ready(out_ready), .select(select), .illegal(illegal),
        .disp_cnt(disp_cnt), .err_cnt(err_cnt)
    );

    opcode_decoder_pipe #(.OPW(3), .CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .opcode(opcode4), .en_mask(en_mask4),
        .out_valid(out_valid4), .out_ready(out_ready4), .select(select4), .illegal(illegal4),
        .disp_cnt(disp_cnt4), .err_cnt(err_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = 3'd0; en_mask = 8'hFF; out_ready = 1'b0;
        in_valid4 = 1'b0; opcode4 = 3'd0; en_mask4 = 8'h00; out_ready4 = 1'b1;

        // Reset state
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_disp", 32'(disp_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        // 1: legal opcode 5, one-cycle latency
        in_valid = 1'b1; opcode = 3'b101; en_mask = 8'hFF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_select", 32'(select), 32'h20);
        chk("t1_illegal", 32'(illegal), 32'd0);
        step();
        chk("t1_disp", 32'(disp_cnt), 32'd1);
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: masked opcode 2 is illegal
        in_valid = 1'b1; opcode = 3'b010; en_mask = 8'hFB; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_select", 32'(select), 32'h00);
        chk("t2_illegal", 32'(illegal), 32'd1);
        chk("t2_err", 32'(err_cnt), 32'd1);
        out_ready = 1'b1;
        step();
        chk("t2_disp", 32'(disp_cnt), 32'd2);
        chk("t2_drained", 32'(out_valid), 32'd0);

        // 3: fill with 0 then 7, hold, then drain in order
        out_ready = 1'b0; en_mask = 8'hFF; in_valid = 1'b1; opcode = 3'd0;
        step();
        chk("t3_ready_occ1", 32'(in_ready), 32'd1);
        opcode = 3'd7;
        step();
        in_valid = 1'b0;
        chk("t3_ready_full", 32'(in_ready), 32'd0);
        chk("t3_head0", 32'(select), 32'h01);
        step();
        chk("t3_hold", 32'(select), 32'h01);
        chk("t3_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("t3_ready_full_pop", 32'(in_ready), 32'd0);
        step();
        chk("t3_head1", 32'(select), 32'h80);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("t3_empty", 32'(out_valid), 32'd0);
        chk("t3_disp", 32'(disp_cnt), 32'd4);

        // 4: back-to-back 0..7, one transfer per cycle
        out_ready = 1'b1; in_valid = 1'b1; en_mask = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            opcode = 3'(i);
            step();
            chk($sformatf("t4_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t4_sel%0d", i), 32'(select), 32'(1 << i));
            chk($sformatf("t4_ready%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t4_disp", 32'(disp_cnt), 32'd12);
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_empty", 32'(out_valid), 32'd0);

        // 5: CNTW=4 error counter saturates at F
        in_valid4 = 1'b1; opcode4 = 3'd2; en_mask4 = 8'h00;
        repeat (14) step();
        chk("t5_err14", 32'(err_cnt4), 32'hE);
        chk("t5_illegal", 32'(illegal4), 32'd1);
        repeat (6) step();
        chk("t5_err20", 32'(err_cnt4), 32'hF);
        chk("t5_disp_sat", 32'(disp_cnt4), 32'hF);
        in_valid4 = 1'b0;

        // 6: reset while full discards entries
        out_ready = 1'b0; in_valid = 1'b1; opcode = 3'd3; en_mask = 8'hFF;
        step(); step();
        chk("t6_full", 32'(in_ready), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        step();
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_disp", 32'(disp_cnt), 32'd0);
        chk("t6_rst_err", 32'(err_cnt), 32'd0);
        chk("t6_rst_select", 32'(select), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        step();
        chk("t6_rel_ready", 32'(in_ready), 32'd1);
        chk("t6_rel_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        chk("t6_no_stale", 32'(out_valid), 32'd0);
        chk("t6_disp_zero", 32'(disp_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
